ps2_key_receiver: RTL and testbench
===================================

// Module: ps2_key_receiver
// PURPOSE
//  Receives PS/2 keyboard frames and presents one scan code per keypress as a one-cycle key_ready pulse with key_code.
//  Sits directly upstream of the BRAM write-address stage.
//  That stage writes key_code to RAM on every key_ready, so this block emits only validated make codes.
//  Break sequences are suppressed when KEY_BREAK_FILTER_EN is defined.
// PARAMETERS
//  FILTER_LEN      4       cycles a synchronized ps2_clk level must hold before it is accepted (glitch filter)
//  TIMEOUT_CYCLES  200000  idle clk cycles inside a frame before the frame is aborted (2 ms at 100 MHz)
// PORTS
//  clk           in   1  system clock; all logic on posedge
//  rst           in   1  asynchronous, active-high reset
//  ps2_clk       in   1  raw PS/2 clock from connector, asynchronous
//  ps2_data      in   1  raw PS/2 data from connector, asynchronous
//  key_ready     out  1  one-cycle pulse: key_code valid
//  key_code      out  8  scan code; held until next key_ready
//  key_extended  out  1  code was E0-prefixed; same timing as key_code
//  frame_error   out  1  one-cycle pulse on parity, stop or timeout error
// BEHAVIOUR
//  - Reset: key_ready=0, key_code=8'h00, key_extended=0, frame_error=0, FSM=IDLE, prefix flags clear, timeout counter 0.
//  - Reset mid-frame discards the partial frame; no pulse follows reset release.
//  - Input path: ps2_clk and ps2_data each pass through a 2-flop synchronizer.
//  - Filtered clock level changes only after FILTER_LEN consecutive equal samples.
//  - A bit is sampled on the filtered-clock 1->0 transition (the "fall" cycle), from synchronized ps2_data.
//  - Frame format: start(0), D0..D7 LSB first, odd parity, stop(1).
//  - FSM states and transitions:
//    IDLE -> DATA on fall with data=0. A fall with data=1 is ignored: stay in IDLE, no error.
//    DATA: shift in 8 bits; 3-bit counter; after the 8th fall -> PARITY.
//    PARITY: capture bit -> STOP.
//    STOP on fall: if stop=1 and ^{D,parity}=1 -> DONE; otherwise frame_error pulse and -> IDLE.
//    DONE: single cycle; prefix/emit decision (below) -> IDLE.
//  - Timeout: in DATA/PARITY/STOP, counter increments each clk and clears on each fall.
//    Reaching TIMEOUT_CYCLES-1 -> frame_error pulse, data discarded, -> IDLE.
//    Counter held at 0 in IDLE.
//  - Latency: key_ready / frame_error (parity/stop) asserted the cycle after the stop-bit fall cycle; high exactly 1 cycle.
//  - Prefix handling in DONE (valid byte B):
//    B=8'hE0 -> set ext_pending; no pulse.
//    B=8'hF0 -> set brk_pending; no pulse.
//    Otherwise: emit, unless suppressed (see CONFIGURATION); clear both flags.
//    On emit: key_code=B, key_extended=ext_pending.
//  - frame_error clears ext_pending and brk_pending.
//  - A pulse is never asserted in two consecutive cycles (frames are >=11 falls apart).
//  - key_ready and frame_error are never asserted together.
// CONFIGURATION
//  KEY_BREAK_FILTER_EN defined:
//    - Prefix handling as above.
//    - A non-prefix byte with brk_pending=1 is suppressed (no key_ready); flags cleared.
//    - Key releases never reach RAM.
//  KEY_BREAK_FILTER_EN undefined:
//    - No prefix handling; every valid byte, including E0 and F0, pulses key_ready with key_code=B.
//    - key_extended tied 0.
// TESTING
//  - Reset: assert rst mid-frame after 4 data bits, release, send valid frame 8'h1C -> exactly one key_ready, key_code=8'h1C, key_extended=0.
//  - Make code: frame 8'h1C, parity 0 -> key_ready one cycle after stop fall, key_code=8'h1C; frame_error stays 0.
//  - Parity error: 8'h1C with parity 1 -> frame_error one pulse, no key_ready, key_code unchanged.
//  - Break/extended (macro on):
//    - F0,1C -> no key_ready.
//    - E0,75 -> key_ready, key_code=8'h75, key_extended=1.
//    - E0,F0,75 -> nothing.
//  - Timeout: send start + 3 bits then stop toggling -> frame_error after TIMEOUT_CYCLES.
//    Next valid frame 8'h2B -> key_code=8'h2B.
//  - Glitch: ps2_clk low pulse of FILTER_LEN-2 cycles while IDLE with data=0 -> no state change, no pulse.

Source files
------------

// File: rtl/ps2_key_receiver.sv
// rtl/ps2_key_receiver.sv - PS/2 keyboard frame receiver emitting one validated scan code per key
//
// Purpose:
//   Synchronizes and glitch-filters the raw PS/2 clock/data pair, deframes
//   start/8 data/odd parity/stop frames and presents each accepted byte as a
//   one-cycle key_ready pulse with key_code (held until the next pulse).
//   Parity, stop-bit and inter-bit timeout errors give a one-cycle frame_error.
//
// Optional feature macro: KEY_BREAK_FILTER_EN
//   defined   : E0 / F0 prefix bytes are absorbed; a byte following F0 is
//               suppressed; key_extended reports an E0 prefix.
//   undefined : every valid byte pulses key_ready; key_extended is tied 0.
//
// Parameters:
//   FILTER_LEN      consecutive synchronized samples needed to accept a ps2_clk level
//   TIMEOUT_CYCLES  clk cycles without a falling edge inside a frame before abort
//
// Ports:
//   clk           in   system clock, posedge
//   rst           in   asynchronous active-high reset
//   ps2_clk       in   raw PS/2 clock (asynchronous)
//   ps2_data      in   raw PS/2 data (asynchronous)
//   key_ready     out  one-cycle pulse, key_code/key_extended valid
//   key_code      out  8-bit scan code, held until the next key_ready
//   key_extended  out  code was E0-prefixed
//   frame_error   out  one-cycle pulse on parity, stop or timeout error

module ps2_key_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       frame_error
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers (reset to the idle-high line level so that reset
    // release never manufactures a falling edge)
    // ------------------------------------------------------------------
    logic r_clk_s1;
    logic r_clk_s2;
    logic r_dat_s1;
    logic r_dat_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // ------------------------------------------------------------------
    // Glitch filter: the filtered level follows the synchronized clock only
    // after FILTER_LEN consecutive samples disagree with the current level.
    // ------------------------------------------------------------------
    logic          r_filt_clk;
    logic          r_filt_prev;
    logic [FW-1:0] r_filt_cnt;
    logic          w_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt_clk  <= 1'b1;
            r_filt_prev <= 1'b1;
            r_filt_cnt  <= '0;
        end else begin
            r_filt_prev <= r_filt_clk;
            if (r_clk_s2 == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt_clk <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_filt_prev & ~r_filt_clk;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_parity;
    logic [TW-1:0] r_tmo_cnt;
    logic          w_tmo_hit;
    logic          w_in_frame;
    logic          w_frame_ok;
    logic          w_err;
    logic          w_byte_ok;
    logic          w_emit;

    assign w_tmo_hit  = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_in_frame = (r_state == S_DATA) || (r_state == S_PARITY) || (r_state == S_STOP);
    // Evaluated on the stop-bit fall: stop must be 1 and data+parity odd.
    assign w_frame_ok = r_dat_s2 & (^{r_shift, r_parity});

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a fall always wins over a coincident timeout
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fall && !r_dat_s2) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_fall) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_PARITY;
                    end
                end else if (w_tmo_hit) begin
                    w_state_next = S_IDLE;
                end
            end
            S_PARITY: begin
                if (w_fall) begin
                    w_state_next = S_STOP;
                end else if (w_tmo_hit) begin
                    w_state_next = S_IDLE;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    w_state_next = w_frame_ok ? S_DONE : S_IDLE;
                end else if (w_tmo_hit) begin
                    w_state_next = S_IDLE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifdef KEY_BREAK_FILTER_EN
    logic r_ext_pending;
    logic r_brk_pending;
    logic w_is_e0;
    logic w_is_f0;
    logic w_set_ext;
    logic w_set_brk;
    logic w_clr_flags;

    assign w_is_e0 = (r_shift == 8'hE0);
    assign w_is_f0 = (r_shift == 8'hF0);
`endif

    // Output/control decode. The emit decision is taken on the stop-bit fall
    // so the pulse lands in the DONE cycle; the prefix flags it depends on do
    // not change until DONE updates them.
    always_comb begin
        w_err     = 1'b0;
        w_byte_ok = 1'b0;
        if ((r_state == S_STOP) && w_fall) begin
            w_byte_ok = w_frame_ok;
            w_err     = ~w_frame_ok;
        end else if (w_in_frame && !w_fall && w_tmo_hit) begin
            w_err = 1'b1;
        end
`ifdef KEY_BREAK_FILTER_EN
        w_emit      = w_byte_ok && !w_is_e0 && !w_is_f0 && !r_brk_pending;
        w_set_ext   = (r_state == S_DONE) && w_is_e0;
        w_set_brk   = (r_state == S_DONE) && w_is_f0;
        w_clr_flags = w_err || ((r_state == S_DONE) && !w_is_e0 && !w_is_f0);
`else
        w_emit = w_byte_ok;
`endif
    end

    // Shift register, bit counter and parity capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_parity  <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_bit_cnt <= 3'd0;
            end else if ((r_state == S_DATA) && w_fall) begin
                r_shift   <= {r_dat_s2, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if ((r_state == S_PARITY) && w_fall) begin
                r_parity <= r_dat_s2;
            end
        end
    end

    // Inter-bit timeout counter, held at 0 outside a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (!w_in_frame || w_fall) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Registered outputs
    logic       r_key_ready;
    logic [7:0] r_key_code;
    logic       r_frame_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_ready   <= 1'b0;
            r_key_code    <= 8'h00;
            r_frame_error <= 1'b0;
        end else begin
            r_key_ready   <= w_emit;
            r_frame_error <= w_err;
            if (w_emit) begin
                r_key_code <= r_shift;
            end
        end
    end

    assign key_ready   = r_key_ready;
    assign key_code    = r_key_code;
    assign frame_error = r_frame_error;

`ifdef KEY_BREAK_FILTER_EN
    logic r_key_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext_pending <= 1'b0;
            r_brk_pending <= 1'b0;
            r_key_ext     <= 1'b0;
        end else begin
            if (w_clr_flags) begin
                r_ext_pending <= 1'b0;
                r_brk_pending <= 1'b0;
            end else begin
                if (w_set_ext) begin
                    r_ext_pending <= 1'b1;
                end
                if (w_set_brk) begin
                    r_brk_pending <= 1'b1;
                end
            end
            if (w_emit) begin
                r_key_ext <= r_ext_pending;
            end
        end
    end

    assign key_extended = r_key_ext;
`else
    assign key_extended = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb/tb_ps2_key_receiver.sv - randomized PS/2 frame bench with a queue-based event model

module tb_ps2_key_receiver;

    localparam int FLEN = 4;
    localparam int TMO  = 300;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_extended;
    logic       frame_error;

    ps2_key_receiver #(
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_ready    (key_ready),
        .key_code     (key_code),
        .key_extended (key_extended),
        .frame_error  (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic       ext;
    } ev_t;

    ev_t        q[$];
    logic [7:0] m_code = 8'h00;
    logic       m_ext  = 1'b0;
`ifdef KEY_BREAK_FILTER_EN
    bit m_ext_p = 0;
    bit m_brk_p = 0;
`endif

    task automatic push_ev(input bit is_err, input logic [7:0] code, input logic ext);
        ev_t e;
        e.is_err = is_err;
        e.code   = code;
        e.ext    = ext;
        q.push_back(e);
    endtask

    task automatic model_frame(input logic [7:0] b, input bit ok);
        if (!ok) begin
            push_ev(1'b1, 8'h00, 1'b0);
`ifdef KEY_BREAK_FILTER_EN
            m_ext_p = 0;
            m_brk_p = 0;
`endif
        end else begin
`ifdef KEY_BREAK_FILTER_EN
            if (b == 8'hE0) m_ext_p = 1;
            else if (b == 8'hF0) m_brk_p = 1;
            else begin
                if (!m_brk_p) push_ev(1'b0, b, m_ext_p);
                m_ext_p = 0;
                m_brk_p = 0;
            end
`else
            push_ev(1'b0, b, 1'b0);
`endif
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_code = 8'h00;
        m_ext  = 1'b0;
`ifdef KEY_BREAK_FILTER_EN
        m_ext_p = 0;
        m_brk_p = 0;
`endif
    endtask

    // ---------------- compare process ----------------
    bit         chk_en   = 0;
    bit         prev_pls = 0;
    int         n_ready  = 0;
    int         n_ferr   = 0;
    int         rdy_cyc  = 0;
    int         err_cyc  = 0;
    logic [7:0] last_code = 8'h00;
    logic       last_ext  = 1'b0;

    always @(negedge clk) begin
        if (rst || !chk_en) begin
            prev_pls = 0;
        end else begin
            ev_t e;
            if (key_ready && frame_error) chk("ready_and_error_together", 1, 0);
            if (key_ready) begin
                n_ready++;
                rdy_cyc   = cyc;
                last_code = key_code;
                last_ext  = key_extended;
                if (q.size() == 0 || q[0].is_err) begin
                    chk("unexpected_key_ready", {24'h0, key_code}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("key_code", {24'h0, key_code}, {24'h0, e.code});
                    chk("key_extended", {31'h0, key_extended}, {31'h0, e.ext});
                    m_code = e.code;
                    m_ext  = e.ext;
                end
            end
            if (frame_error) begin
                n_ferr++;
                err_cyc = cyc;
                if (q.size() == 0 || !q[0].is_err) begin
                    chk("unexpected_frame_error", 1, 0);
                end else begin
                    e = q.pop_front();
                    n_vec++;
                end
            end
            if ((key_ready || frame_error) && prev_pls) chk("pulse_back_to_back", 1, 0);
            prev_pls = key_ready || frame_error;
            chk("held_code", {23'h0, key_extended, key_code}, {23'h0, m_ext, m_code});
        end
    end

    // ---------------- stimulus ----------------
    int t_drop = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        tick($urandom_range(14, 8));
        ps2_clk = 1'b0;
        t_drop  = cyc;
        tick($urandom_range(16, 12));
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        model_frame(b, !bad_par && !bad_stop);
        p = (~^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(!bad_stop);
        tick(4);
        ps2_data = 1'b1;
        tick(4);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) tick(1);
        chk("model_queue_drained", q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_key_ready"}, {31'h0, key_ready}, 0);
        chk({tag, "_key_code"}, {24'h0, key_code}, 0);
        chk({tag, "_key_extended"}, {31'h0, key_extended}, 0);
        chk({tag, "_frame_error"}, {31'h0, frame_error}, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int e0;
        logic [7:0] b;
        logic [7:0] tc;

        tc       = 8'h1C;
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(2);
        chk_en = 1;

        // reset in the middle of a frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(tc[i]);
        #1 rst = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        #1 check_reset_outputs("midframe_reset");
        model_reset();
        tick(3);
        rst = 1'b0;
        tick(20);
        r0 = n_ready;
        send_frame(8'h1C, 0, 0);
        drain();
        chk("after_reset_ready_count", n_ready - r0, 1);
        chk("after_reset_code", {24'h0, last_code}, 32'h1C);
        chk("after_reset_ext", {31'h0, last_ext}, 0);

        // make code with latency window from the stop-bit fall
        r0 = n_ready;
        e0 = n_ferr;
        send_frame(8'h1C, 0, 0);
        drain();
        chk("make_ready_count", n_ready - r0, 1);
        chk("make_no_error", n_ferr - e0, 0);
        chk("make_latency_ok", ((rdy_cyc - t_drop) >= FLEN + 1 && (rdy_cyc - t_drop) <= FLEN + 6), 1);

        // parity and stop errors
        r0 = n_ready;
        e0 = n_ferr;
        send_frame(8'h1C, 1, 0);
        drain();
        send_frame(8'h33, 0, 1);
        drain();
        chk("error_no_ready", n_ready - r0, 0);
        chk("error_count", n_ferr - e0, 2);
        chk("error_code_held", {24'h0, key_code}, 32'h1C);

        // prefix sequences
        r0 = n_ready;
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        drain();
`ifdef KEY_BREAK_FILTER_EN
        chk("break_suppressed", n_ready - r0, 0);
`else
        chk("break_passthrough", n_ready - r0, 2);
`endif
        r0 = n_ready;
        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        drain();
        chk("ext_code", {24'h0, last_code}, 32'h75);
`ifdef KEY_BREAK_FILTER_EN
        chk("ext_count", n_ready - r0, 1);
        chk("ext_flag", {31'h0, last_ext}, 1);
`else
        chk("ext_count", n_ready - r0, 2);
        chk("ext_flag", {31'h0, last_ext}, 0);
`endif
        r0 = n_ready;
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        drain();
`ifdef KEY_BREAK_FILTER_EN
        chk("ext_break_count", n_ready - r0, 0);
`else
        chk("ext_break_count", n_ready - r0, 3);
`endif

        // timeout: start + 3 bits then silence
        e0 = n_ferr;
        model_frame(8'h00, 0);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        tick(TMO + 40);
        chk("timeout_error_count", n_ferr - e0, 1);
        chk("timeout_window_ok", ((err_cyc - t_drop) >= TMO && (err_cyc - t_drop) <= TMO + FLEN + 10), 1);
        send_frame(8'h2B, 0, 0);
        drain();
        chk("after_timeout_code", {24'h0, last_code}, 32'h2B);

        // short clock glitch with data low while idle
        r0 = n_ready;
        e0 = n_ferr;
        ps2_data = 1'b0;
        tick(3);
        ps2_clk = 1'b0;
        tick(FLEN - 2);
        ps2_clk = 1'b1;
        tick(10);
        ps2_data = 1'b1;
        tick(5);
        chk("glitch_no_pulse", (n_ready - r0) + (n_ferr - e0), 0);
        send_frame(8'h4D, 0, 0);
        drain();
        chk("after_glitch_code", {24'h0, last_code}, 32'h4D);

        // randomized frames
        for (int k = 0; k < 90; k++) begin
            int sel;
            sel = $urandom_range(9, 0);
            if (sel == 0) b = 8'hE0;
            else if (sel == 1) b = 8'hF0;
            else b = 8'($urandom_range(255, 0));
            sel = $urandom_range(19, 0);
            send_frame(b, sel == 0, sel == 1);
            drain();
        end

        tick(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
